// File: rtl/en_stack_pkg.sv
// Shared op encodings for the per-lane enable-mask stack.
// Imported by en_stack and by the processor decode logic.
package en_stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ALLEN  = 3'd1,
    OP_PUSHEN = 3'd2,
    OP_POPEN  = 3'd3,
    OP_JUMPF  = 3'd4,
    OP_ELSE   = 3'd5
  } en_op_t;

  localparam int EN_OP_W = 3;

endpackage

// File: rtl/en_stack.sv
// Per-lane enable-mask stack: live top mask plus saved nesting levels.
// en gates writeback, stores and traps for each lane.
module en_stack
  import en_stack_pkg::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  input  logic [EN_OP_W-1:0]       op,
  input  logic [LANES-1:0]         cond,
  input  logic                     err_clr,
  output logic [LANES-1:0]         en,
  output logic                     any_en,
  output logic [$clog2(DEPTH)-1:0] count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH - 1);

  logic [LANES-1:0] top;
  logic [LANES-1:0] top_nxt;
  logic [LANES-1:0] parent;
  logic [LANES-1:0] saved [DEPTH-1];
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    below;
  logic             full;
  logic             empty;
  logic             push;
  logic             set_ovf;
  logic             set_udf;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign below  = count - CW'(1);
  // Outermost level has no enclosing mask, so every lane is allowed.
  assign parent = empty ? '1 : saved[below];
  assign en     = top;

  always_comb begin
    top_nxt   = top;
    count_nxt = count;
    push      = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    unique case (1'b1)
      op_valid && (op == OP_ALLEN): begin
        top_nxt = parent;
      end
      op_valid && (op == OP_PUSHEN): begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          push      = 1'b1;
          count_nxt = count + CW'(1);
        end
      end
      op_valid && (op == OP_POPEN): begin
        if (empty) begin
          top_nxt = '1;
          set_udf = 1'b1;
        end else begin
          top_nxt   = saved[below];
          count_nxt = below;
        end
      end
      op_valid && (op == OP_JUMPF): begin
        top_nxt = top & ~cond;
      end
      op_valid && (op == OP_ELSE): begin
        top_nxt = parent & ~top;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top       <= '1;
      any_en    <= 1'b1;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      top       <= top_nxt;
      any_en    <= |top_nxt;
      count     <= count_nxt;
      overflow  <= set_ovf | (overflow & ~err_clr);
      underflow <= set_udf | (underflow & ~err_clr);
    end
  end

  // Saved levels hold no meaningful value until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      saved[count] <= top;
    end
  end

endmodule

// File: tb/tb_en_stack.sv
// Randomized check of en_stack (LANES=4, DEPTH=4) against a queue model.
// Directed nesting, overflow, underflow and reset cases run first.
module tb_en_stack;
  import en_stack_pkg::*;

  localparam int LANES = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             op_valid = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [LANES-1:0] cond = '0;
  logic             err_clr = 1'b0;
  logic [LANES-1:0] en;
  logic             any_en;
  logic [1:0]       count;
  logic             overflow;
  logic             underflow;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] m_top;
  logic [3:0] m_stk [$];
  bit         m_ovf;
  bit         m_udf;

  en_stack #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .cond(cond), .err_clr(err_clr), .en(en), .any_en(any_en),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_top = 4'hf;
    m_stk.delete();
    m_ovf = 0;
    m_udf = 0;
  endfunction

  function automatic void model_step(bit v, logic [2:0] o,
                                     logic [3:0] c, bit clr);
    logic [3:0] par;
    par = (m_stk.size() > 0) ? m_stk[$] : 4'hf;
    if (clr) begin
      m_ovf = 0;
      m_udf = 0;
    end
    if (v) begin
      case (o)
        3'd1: m_top = par;
        3'd2: begin
          if (m_stk.size() == DEPTH - 1) m_ovf = 1;
          else m_stk.push_back(m_top);
        end
        3'd3: begin
          if (m_stk.size() == 0) begin
            m_top = 4'hf;
            m_udf = 1;
          end else begin
            m_top = m_stk.pop_back();
          end
        end
        3'd4: m_top = m_top & ~c;
        3'd5: m_top = par & ~m_top;
        default: ;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".en"}, 32'(en), 32'(m_top));
    check({tag, ".any"}, 32'(any_en), 32'(|m_top));
    check({tag, ".cnt"}, 32'(count), 32'(m_stk.size()));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".udf"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic do_op(input string tag, input bit v, input logic [2:0] o,
                       input logic [3:0] c, input bit clr);
    @(negedge clk);
    op_valid = v;
    op = o;
    cond = c;
    err_clr = clr;
    @(posedge clk);
    #1;
    model_step(v, o, c, clr);
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    op_valid = 1'b0;
    err_clr = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all("rst0");
    reset = 1'b1;
    #1;
    check("rst_en", 32'(en), 32'hf);

    // nesting
    do_op("n1", 1, OP_JUMPF, 4'b0101, 0);
    check("n1c", 32'(en), 32'b1010);
    do_op("n2", 1, OP_PUSHEN, 4'b0000, 0);
    check("n2c", 32'(count), 32'd1);
    do_op("n3", 1, OP_JUMPF, 4'b1000, 0);
    check("n3c", 32'(en), 32'b0010);
    do_op("n4", 1, OP_ELSE, 4'b0000, 0);
    check("n4c", 32'(en), 32'b1000);
    do_op("n5", 1, OP_POPEN, 4'b0000, 0);
    check("n5c", 32'(en), 32'b1010);

    // allen respects enclosing level
    do_op("a1", 1, OP_PUSHEN, 4'b0000, 0);
    do_op("a2", 1, OP_JUMPF, 4'b1111, 0);
    check("a2c", 32'(any_en), 32'd0);
    do_op("a3", 1, OP_ALLEN, 4'b0000, 0);
    check("a3c", 32'(en), 32'b1010);

    // async reset at count=2
    do_op("r1", 1, OP_PUSHEN, 4'b0000, 0);
    check("r1c", 32'(count), 32'd2);
    pulse_reset("rasync");

    // overflow
    for (int i = 0; i < 3; i++) do_op("o_push", 1, OP_PUSHEN, 4'b0000, 0);
    check("o3c", 32'(count), 32'd3);
    do_op("o4", 1, OP_PUSHEN, 4'b0000, 0);
    check("o4c", 32'(overflow), 32'd1);
    do_op("oclr", 0, OP_NOP, 4'b0000, 1);
    check("oclrc", 32'(overflow), 32'd0);
    do_op("oset", 1, OP_PUSHEN, 4'b0000, 1);
    check("osetc", 32'(overflow), 32'd1);

    // underflow
    pulse_reset("rst2");
    do_op("u1", 1, OP_JUMPF, 4'b1111, 0);
    do_op("u2", 1, OP_POPEN, 4'b0000, 0);
    check("u2c", 32'(underflow), 32'd1);

    // qualification
    do_op("q0", 1, OP_JUMPF, 4'b0011, 0);
    do_op("q1", 0, OP_PUSHEN, 4'b0000, 0);
    do_op("q2", 1, 3'd6, 4'b1111, 0);
    do_op("q3", 1, 3'd7, 4'b1111, 0);
    check("q3c", 32'(en), 32'b1100);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        do_op("rnd", ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
              4'($urandom), ($urandom_range(0, 15) == 0));
      end
    end

    @(negedge clk);
    op_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/en_stack.md
# en_stack

Parametrised per-lane enable-mask stack for the pipelined SIMD-style processor. It generalises the single-lane 32-entry `enstack` shift register to `LANES` lanes and `DEPTH` nesting levels, and adds an `ELSE` mask-flip operation, a parent-aware `ALLEN`, occupancy tracking, and sticky overflow/underflow flags. It sits beside the stage-2 writeback logic. Its `en` output gates register writes, stores and traps for each lane.

## Interface
Parameters:
- `LANES`, default 1: number of independent enable lanes (1..32).
- `DEPTH`, default 32: total mask entries, including the live top (2..256, power of two).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  qualifies `op`; when low, no state changes.
- `op`  in  3  0 NOP, 1 ALLEN, 2 PUSHEN, 3 POPEN, 4 JUMPF, 5 ELSE, 6–7 reserved (treated as NOP).
- `cond`  in  LANES  per-lane branch condition for JUMPF (1 = lane's d-value is zero).
- `err_clr`  in  1  clears both sticky flags.
- `en`  out  LANES  current top mask (registered).
- `any_en`  out  1  OR-reduction of `en` (registered).
- `count`  out  $clog2(DEPTH)  number of saved entries below the top, 0..DEPTH-1.
- `overflow`  out  1  sticky; set by PUSHEN when full.
- `underflow`  out  1  sticky; set by POPEN when empty.

## Operation
- State:
  - `top` register (LANES bits).
  - `saved[0..DEPTH-2]` array (LANES bits each).
  - `count`.
- Definitions:
  - `parent` = `saved[count-1]` if `count>0`, else all-ones.
  - Full: `count==DEPTH-1`.
  - Empty: `count==0`.
- Ops, applied when `op_valid`=1:
  - ALLEN: `top <= parent`. Lanes disabled by an enclosing level stay disabled.
  - PUSHEN, not full: `saved[count] <= top`; `count <= count+1`; `top` unchanged (duplicated).
  - PUSHEN, full: no state change; `overflow <= 1`.
  - POPEN, not empty: `top <= saved[count-1]`; `count <= count-1`.
  - POPEN, empty: `top <= all-ones`; `count` stays 0; `underflow <= 1`.
  - JUMPF: `top <= top & ~cond`.
  - ELSE: `top <= parent & ~top`.
  - NOP / reserved: no change.
- `err_clr` and a same-cycle flag set: the set wins (the flag stays 1).
- Lanes are fully independent. No cross-lane arithmetic.
- All widths are exact. `count` never wraps, because the full and empty guards block it.

## Timing
- Reset (`reset`=0, asynchronous):
  - `top` = all-ones, so `en` = all-ones and `any_en` = 1.
  - `count` = 0; `overflow` = 0; `underflow` = 0.
  - `saved` contents are don't-care.
- Latency: an op sampled at edge N is visible on `en`, `any_en` and `count` immediately after edge N. Exactly one op is accepted per cycle, with back-to-back ops allowed.
- `cond` is sampled only with JUMPF at the same edge.
- Reset asserted mid-sequence aborts any op in that cycle. Deassertion takes effect at the next edge; the first op is accepted on the first rising edge with `reset`=1.
- The processor drives `op` from the stage-1 op. The resulting `en` applies to the instruction that follows, as the existing stage-2 gating does.

## Structure
- Op encodings, `en_op_t`, live in the shared processor package, alongside the `OP*` constants.
- No sub-module. `saved` is a plain register array, with no RAM macro.
- The processor instantiates `en_stack` with `LANES=1, DEPTH=32` to replace the inline `enstack` logic.

## Test plan
All scenarios use `LANES=4`, `DEPTH=4`.
- Reset: release `reset` -> `en`=4'b1111, `any_en`=1, `count`=0, both flags 0. Assert `reset` asynchronously at `count`=2 -> the same values immediately, with no clock edge.
- Nesting: JUMPF `cond`=0101 -> `en`=1010; PUSHEN -> `count`=1, `en`=1010; JUMPF `cond`=1000 -> `en`=0010; ELSE -> `en`=1000; POPEN -> `en`=1010, `count`=0.
- ALLEN: at `count`=1 with `saved[0]`=1010, JUMPF `cond`=1111 -> `en`=0000, `any_en`=0; ALLEN -> `en`=1010, `any_en`=1.
- Overflow: three PUSHENs -> `count`=3; fourth PUSHEN -> `overflow`=1, `count`=3, `en` unchanged. Assert `err_clr` -> `overflow`=0.
- Underflow: POPEN at `count`=0 after JUMPF `cond`=1111 -> `en`=1111, `underflow`=1, `count`=0.
- Qualification: `op`=PUSHEN with `op_valid`=0 -> no change. `op`=6 with `op_valid`=1 -> no change.
